recovery_csr_ctrl: RTL and testbench
====================================

// Module: recovery_csr_ctrl
// PURPOSE
// Sequencer for the ECC-protected recovery CSR store in the HMR recovery path.
// - Normal operation: gates per-cycle CSR backup writes into the store.
// - Fault (DMR/TMR mismatch): halts the core group and opens the store for
//   reading, then steps the core through restoring each CSR.
// - After restore: issues a resume pulse. A halt that is never acknowledged
//   lands in a sticky error state.
// PARAMETERS
// NumCsrs     7    number of CSRs restored in sequence (mstatus..mcause), >=1
// AckTimeout  255  max cycles waiting for halted_i before error, >=1
// CntWidth    8    width of recovery_count_o (saturating)
// PORTS
// clk_i              in   1                   clock
// rst_i              in   1                   async reset, active-high
// backup_valid_i     in   1                   core CSR snapshot valid this cycle
// fault_i            in   1                   mismatch detected (level or pulse)
// halted_i           in   1                   core group acknowledges halt
// restore_ready_i    in   1                   core accepted current restore beat
// clear_error_i      in   1                   leave ERROR state
// csr_write_enable_o out  1                   write enable to CSR store
// csr_read_enable_o  out  1                   read enable to CSR store
// halt_req_o         out  1                   halt request to core group
// restore_valid_o    out  1                   restore beat valid
// restore_addr_o     out  $clog2(NumCsrs)(>=1) index of CSR being restored
// resume_o           out  1                   one-cycle resume pulse
// busy_o             out  1                   state != IDLE
// error_o            out  1                   in ERROR state
// recovery_count_o   out  CntWidth            completed recoveries, saturating
// BEHAVIOUR
// - States: IDLE, HALT, RESTORE, RESUME, ERROR. Reset: IDLE, all outputs 0,
//   timer = 0, idx = 0, count = 0.
// - Output timing:
//   - All outputs except csr_write_enable_o are registered or state-decoded.
//   - csr_write_enable_o = (state==IDLE) & backup_valid_i & ~fault_i
//     (combinational). A fault in the same cycle suppresses the suspect
//     snapshot.
// - IDLE: fault_i=1 -> HALT next cycle. halt_req_o rises 1 cycle after fault_i.
// - HALT:
//   - halt_req_o=1; timer increments each cycle.
//   - halted_i=1 -> RESTORE, idx=0, timer=0. This has priority over timeout.
//   - Otherwise timer==AckTimeout-1 -> ERROR.
// - RESTORE:
//   - halt_req_o=1, csr_read_enable_o=1, restore_valid_o=1, restore_addr_o=idx.
//   - valid and addr stay stable until restore_ready_i.
//   - On ready: if idx==NumCsrs-1 -> RESUME, else idx+1.
//   - One beat per cycle is possible when ready is held high.
// - RESUME:
//   - resume_o=1 for exactly one cycle; halt_req_o=0.
//   - count += 1, saturating at 2^CntWidth-1.
//   - -> IDLE.
// - ERROR:
//   - halt_req_o=1, error_o=1.
//   - clear_error_i -> IDLE; halt_req_o drops; count unchanged.
// - fault_i is ignored outside IDLE; no queuing. A fault still high on
//   return to IDLE starts a new recovery.
// - Store writes are blocked in every non-IDLE state.
// - Async reset mid-sequence: immediate return to IDLE; outputs clear
//   without waiting for a clock edge.
// TESTING
// - Backup: backup_valid_i=1 for 5 cycles, no fault -> csr_write_enable_o
//   high those 5 cycles; busy_o=0.
// - Full recovery, NumCsrs=7:
//   - fault_i pulse at t -> halt_req_o=1 at t+1; halted_i at t+3.
//   - restore_ready_i always 1 -> addrs 0..6 on cycles t+4..t+10.
//   - resume_o at t+11; count=1; IDLE at t+12.
// - Backpressure: ready low 3 cycles on addr 2 -> addr 2 and valid held
//   stable, no skip; addr 3 follows the ready cycle.
// - Timeout: AckTimeout=4, halted_i never -> ERROR after 4 HALT cycles;
//   error_o=1, halt_req_o=1.
//   - clear_error_i -> IDLE, count unchanged.
// - Corner cases:
//   - fault_i with backup_valid_i same cycle -> no write.
//   - fault_i during RESTORE -> ignored.
//   - rst_i mid-RESTORE -> all outputs 0 immediately.
//   - 256 recoveries with CntWidth=8 -> count saturates at 255.

Source files
------------

// File: rtl/recovery_csr_ctrl_if.sv
// Signal bundle between the recovery sequencer, the ECC CSR store and the core group.
// The master side is the sequencer; the slave side is the core/store environment.
interface recovery_csr_ctrl_if #(
  parameter int NumCsrs  = 7,
  parameter int CntWidth = 8
);
  localparam int AddrW = (NumCsrs > 1) ? $clog2(NumCsrs) : 1;

  logic                backup_valid_i;
  logic                fault_i;
  logic                halted_i;
  logic                restore_ready_i;
  logic                clear_error_i;
  logic                csr_write_enable_o;
  logic                csr_read_enable_o;
  logic                halt_req_o;
  logic                restore_valid_o;
  logic [AddrW-1:0]    restore_addr_o;
  logic                resume_o;
  logic                busy_o;
  logic                error_o;
  logic [CntWidth-1:0] recovery_count_o;

  modport master (
    input  backup_valid_i, fault_i, halted_i, restore_ready_i, clear_error_i,
    output csr_write_enable_o, csr_read_enable_o, halt_req_o, restore_valid_o,
           restore_addr_o, resume_o, busy_o, error_o, recovery_count_o
  );

  modport slave (
    output backup_valid_i, fault_i, halted_i, restore_ready_i, clear_error_i,
    input  csr_write_enable_o, csr_read_enable_o, halt_req_o, restore_valid_o,
           restore_addr_o, resume_o, busy_o, error_o, recovery_count_o
  );
endinterface

// File: rtl/recovery_csr_ctrl.sv
// Recovery sequencer: gates CSR backups in normal operation, and on a lockstep
// mismatch halts the core group, replays every stored CSR, then resumes it.
module recovery_csr_ctrl #(
  parameter int NumCsrs    = 7,
  parameter int AckTimeout = 255,
  parameter int CntWidth   = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  recovery_csr_ctrl_if.master bus
);
  localparam int AddrW  = (NumCsrs > 1) ? $clog2(NumCsrs) : 1;
  localparam int TimerW = (AckTimeout > 1) ? $clog2(AckTimeout + 1) : 1;
  localparam logic [AddrW-1:0]  LastIdx   = AddrW'(NumCsrs - 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(AckTimeout - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HALT    = 3'd1,
    RESTORE = 3'd2,
    RESUME  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [AddrW-1:0]    idx_reg, idx_next;
  logic [TimerW-1:0]   timer_reg, timer_next;
  logic                halt_req_reg;
  logic                read_en_reg;
  logic                restore_valid_reg;
  logic [AddrW-1:0]    restore_addr_reg;
  logic                resume_reg;
  logic                busy_reg;
  logic                error_reg;
  logic [CntWidth-1:0] count_reg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    timer_next = timer_reg;
    case (state_reg)
      IDLE: begin
        idx_next   = '0;
        timer_next = '0;
        if (bus.fault_i) state_next = HALT;
      end
      HALT: begin
        // An acknowledge arriving on the last allowed cycle still wins.
        if (bus.halted_i) begin
          state_next = RESTORE;
          idx_next   = '0;
          timer_next = '0;
        end else if (timer_reg == TimerLast) begin
          state_next = ERROR;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      RESTORE: begin
        if (bus.restore_ready_i) begin
          if (idx_reg == LastIdx) begin
            state_next = RESUME;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      RESUME: state_next = IDLE;
      ERROR: begin
        if (bus.clear_error_i) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
        timer_next = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg         <= IDLE;
      idx_reg           <= '0;
      timer_reg         <= '0;
      halt_req_reg      <= 1'b0;
      read_en_reg       <= 1'b0;
      restore_valid_reg <= 1'b0;
      restore_addr_reg  <= '0;
      resume_reg        <= 1'b0;
      busy_reg          <= 1'b0;
      error_reg         <= 1'b0;
      count_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      idx_reg           <= idx_next;
      timer_reg         <= timer_next;
      halt_req_reg      <= (state_next == HALT) || (state_next == RESTORE) ||
                           (state_next == ERROR);
      read_en_reg       <= (state_next == RESTORE);
      restore_valid_reg <= (state_next == RESTORE);
      restore_addr_reg  <= (state_next == RESTORE) ? idx_next : '0;
      resume_reg        <= (state_next == RESUME);
      busy_reg          <= (state_next != IDLE);
      error_reg         <= (state_next == ERROR);
      if ((state_reg == RESUME) && (count_reg != {CntWidth{1'b1}})) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // Same-cycle fault drops the suspect snapshot; reset also holds the store closed.
  assign bus.csr_write_enable_o = ~rst_i & (state_reg == IDLE) &
                                  bus.backup_valid_i & ~bus.fault_i;
  assign bus.csr_read_enable_o  = read_en_reg;
  assign bus.halt_req_o         = halt_req_reg;
  assign bus.restore_valid_o    = restore_valid_reg;
  assign bus.restore_addr_o     = restore_addr_reg;
  assign bus.resume_o           = resume_reg;
  assign bus.busy_o             = busy_reg;
  assign bus.error_o            = error_reg;
  assign bus.recovery_count_o   = count_reg;
endmodule

// File: tb/tb_recovery_csr_ctrl.sv
// Directed bench for recovery_csr_ctrl: cycle-by-cycle vector table plus
// hand-written sequences for async reset and counter saturation.
module tb_recovery_csr_ctrl;
  localparam int NumCsrs    = 7;
  localparam int AckTimeout = 4;
  localparam int CntWidth   = 8;

  // Flag order: {we, re, halt_req, restore_valid, resume, busy, error}
  localparam logic [6:0] F_IDL = 7'b0000000;
  localparam logic [6:0] F_WR  = 7'b1000000;
  localparam logic [6:0] F_HLT = 7'b0010010;
  localparam logic [6:0] F_RST = 7'b0111010;
  localparam logic [6:0] F_RSM = 7'b0000110;
  localparam logic [6:0] F_ERR = 7'b0010011;

  // Input order: {backup_valid, fault, halted, restore_ready, clear_error}
  typedef struct {
    logic [4:0] in;
    logic [6:0] flags;
    int         addr;
    int         cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  recovery_csr_ctrl_if #(.NumCsrs(NumCsrs), .CntWidth(CntWidth)) bus ();

  recovery_csr_ctrl #(
    .NumCsrs(NumCsrs),
    .AckTimeout(AckTimeout),
    .CntWidth(CntWidth)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  function automatic vec_t mk(logic [4:0] i, logic [6:0] f, int a, int c);
    vec_t v;
    v.in = i;
    v.flags = f;
    v.addr = a;
    v.cnt = c;
    return v;
  endfunction

  function automatic logic [6:0] flags_now();
    return {bus.csr_write_enable_o, bus.csr_read_enable_o, bus.halt_req_o,
            bus.restore_valid_o, bus.resume_o, bus.busy_o, bus.error_o};
  endfunction

  task automatic drive(logic [4:0] i);
    bus.backup_valid_i  = i[4];
    bus.fault_i         = i[3];
    bus.halted_i        = i[2];
    bus.restore_ready_i = i[1];
    bus.clear_error_i   = i[0];
  endtask

  task automatic chk(string name, int row, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, row, got, exp);
    end
  endtask

  task automatic recover(output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    drive(5'b01110);
    @(posedge clk); #1;
    drive(5'b00110);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.resume_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lost;
    bit ok;

    // Build the vector table: backup, full recovery, backpressure, timeout.
    vecs.push_back(mk(5'b00000, F_IDL, 0, 0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(5'b10000, F_WR, 0, 0));
    vecs.push_back(mk(5'b11000, F_IDL, 0, 0));
    vecs.push_back(mk(5'b10000, F_HLT, 0, 0));
    vecs.push_back(mk(5'b00000, F_HLT, 0, 0));
    vecs.push_back(mk(5'b00100, F_HLT, 0, 0));
    for (int k = 0; k < NumCsrs; k++)
      vecs.push_back(mk({1'b0, (k == 1), 1'b0, 1'b1, 1'b0}, F_RST, k, 0));
    vecs.push_back(mk(5'b00000, F_RSM, 0, 0));
    vecs.push_back(mk(5'b00000, F_IDL, 0, 1));
    vecs.push_back(mk(5'b01000, F_IDL, 0, 1));
    vecs.push_back(mk(5'b00100, F_HLT, 0, 1));
    vecs.push_back(mk(5'b00010, F_RST, 0, 1));
    vecs.push_back(mk(5'b00010, F_RST, 1, 1));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(5'b00000, F_RST, 2, 1));
    vecs.push_back(mk(5'b00010, F_RST, 2, 1));
    for (int k = 3; k < NumCsrs; k++) vecs.push_back(mk(5'b00010, F_RST, k, 1));
    vecs.push_back(mk(5'b00000, F_RSM, 0, 1));
    vecs.push_back(mk(5'b00000, F_IDL, 0, 2));
    vecs.push_back(mk(5'b01000, F_IDL, 0, 2));
    for (int k = 0; k < AckTimeout; k++) vecs.push_back(mk(5'b00000, F_HLT, 0, 2));
    vecs.push_back(mk(5'b00000, F_ERR, 0, 2));
    vecs.push_back(mk(5'b01000, F_ERR, 0, 2));
    vecs.push_back(mk(5'b00001, F_ERR, 0, 2));
    vecs.push_back(mk(5'b00000, F_IDL, 0, 2));
    vecs.push_back(mk(5'b10000, F_WR, 0, 2));

    // Reset state, with a backup request that must not reach the store.
    drive(5'b10000);
    #3;
    $display("reset flags=%b addr=%0d cnt=%0d", flags_now(), bus.restore_addr_o,
             bus.recovery_count_o);
    chk("reset_flags", 0, 32'(flags_now()), 32'(F_IDL));
    chk("reset_addr", 0, 32'(bus.restore_addr_o), 32'd0);
    chk("reset_cnt", 0, 32'(bus.recovery_count_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(5'b00000);

    foreach (vecs[r]) begin
      @(posedge clk); #1;
      drive(vecs[r].in);
      @(negedge clk);
      $display("row %0d in=%b flags=%b addr=%0d cnt=%0d", r, vecs[r].in, flags_now(),
               bus.restore_addr_o, bus.recovery_count_o);
      chk("row_flags", r, 32'(flags_now()), 32'(vecs[r].flags));
      chk("row_addr", r, 32'(bus.restore_addr_o), 32'(vecs[r].addr));
      chk("row_cnt", r, 32'(bus.recovery_count_o), 32'(vecs[r].cnt));
    end

    // Async reset while a restore beat is stalled.
    @(posedge clk); #1;
    drive(5'b01100);
    @(posedge clk); #1;
    drive(5'b00100);
    @(posedge clk); #1;
    drive(5'b00000);
    @(negedge clk);
    $display("pre-reset flags=%b addr=%0d", flags_now(), bus.restore_addr_o);
    chk("midrst_in_restore", 0, 32'(flags_now()), 32'(F_RST));
    #2;
    rst = 1'b1;
    #1;
    $display("mid-reset flags=%b addr=%0d cnt=%0d", flags_now(), bus.restore_addr_o,
             bus.recovery_count_o);
    chk("midrst_flags", 0, 32'(flags_now()), 32'(F_IDL));
    chk("midrst_cnt", 0, 32'(bus.recovery_count_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(5'b10000);
    @(negedge clk);
    $display("post-reset flags=%b", flags_now());
    chk("postrst_write", 0, 32'(flags_now()), 32'(F_WR));
    drive(5'b00000);

    // Counter saturation from a cleared count.
    lost = 0;
    for (int n = 0; n < 254; n++) begin
      recover(ok);
      if (!ok) lost++;
    end
    @(negedge clk);
    $display("after 254 recoveries cnt=%0d", bus.recovery_count_o);
    chk("sat_254", 0, 32'(bus.recovery_count_o), 32'd254);
    recover(ok);
    if (!ok) lost++;
    @(negedge clk);
    $display("after 255 recoveries cnt=%0d", bus.recovery_count_o);
    chk("sat_255", 0, 32'(bus.recovery_count_o), 32'd255);
    recover(ok);
    if (!ok) lost++;
    @(negedge clk);
    $display("after 256 recoveries cnt=%0d", bus.recovery_count_o);
    chk("sat_256", 0, 32'(bus.recovery_count_o), 32'd255);
    chk("sat_resume_seen", 0, 32'(lost), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
